alu_issue_ctrl: RTL and testbench

Sequential front end that owns the operand/result interface of the combinational Hmmm ALU.
- Accepts one command per transaction over a valid/ready handshake.
- Registers the operands and holds them stable on the ALU inputs for a settle window, so multiply/divide can be a multicycle path.
- Captures the ALU result and flags, then presents them to writeback over a second valid/ready handshake.
- Sits between instruction decode/register-file read and register writeback.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_settle_cnt.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared op encodings, data width and FSM states for the ALU issue path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Division-class ops are the only ones that can fault on a zero divisor.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_settle_cnt.sv
// ============================================================================
// Module  : alu_settle_cnt
// Brief   : Loadable down-counter with terminal-count flag for the ALU settle window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_settle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Command/response front end holding ALU operands for a settle window.
//           Optional sticky carry flag under `ALU_STICKY_CARRY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_tmp1,
  output logic [DATA_W-1:0] alu_tmp2,
  output logic [2:0]        alu_op,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_div0
`ifdef ALU_STICKY_CARRY_EN
  ,
  output logic              sticky_carry,
  input  logic              sticky_clr
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0] alu_tmp1_q, alu_tmp1_d;
  logic [DATA_W-1:0] alu_tmp2_q, alu_tmp2_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              alu_enable_q, alu_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_div0_q, rsp_div0_d;

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_tc;
  logic              capture;

  alu_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  assign capture = (state_q == ST_ISSUE) && cnt_tc;

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    alu_tmp1_d   = alu_tmp1_q;
    alu_tmp2_d   = alu_tmp2_q;
    alu_op_d     = alu_op_q;
    alu_enable_d = alu_enable_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_div0_d   = rsp_div0_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          // A zero divisor never reaches the ALU; the fault response is synthesised here.
          if (is_div_op(cmd_op) && (cmd_b == '0)) begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_carry_d  = 1'b0;
            rsp_div0_d   = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            alu_tmp1_d   = cmd_a;
            alu_tmp2_d   = cmd_b;
            alu_op_d     = cmd_op;
            alu_enable_d = 1'b1;
            cnt_load     = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_tc) begin
          state_d      = ST_RESP;
          alu_enable_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_carry_d  = alu_carry;
          rsp_div0_d   = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cmd_ready_d  = 1'b1;
        alu_enable_d = 1'b0;
        rsp_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      alu_tmp1_q   <= '0;
      alu_tmp2_q   <= '0;
      alu_op_q     <= '0;
      alu_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_div0_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_tmp1_q   <= alu_tmp1_d;
      alu_tmp2_q   <= alu_tmp2_d;
      alu_op_q     <= alu_op_d;
      alu_enable_q <= alu_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_div0_q   <= rsp_div0_d;
    end
  end

`ifdef ALU_STICKY_CARRY_EN
  logic sticky_carry_q, sticky_carry_d;

  // Set has priority so a carry captured alongside a clear is never lost.
  always_comb begin
    sticky_carry_d = sticky_carry_q;
    if (sticky_clr) begin
      sticky_carry_d = 1'b0;
    end
    if (capture && alu_carry) begin
      sticky_carry_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_carry_q <= 1'b0;
    end else begin
      sticky_carry_q <= sticky_carry_d;
    end
  end

  assign sticky_carry = sticky_carry_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign alu_tmp1   = alu_tmp1_q;
  assign alu_tmp2   = alu_tmp2_q;
  assign alu_op     = alu_op_q;
  assign alu_enable = alu_enable_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_div0   = rsp_div0_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed bench for alu_issue_ctrl; two instances (SETTLE_CYCLES 1 and 3)
//           each driving a behavioural Hmmm ALU. Honours `ALU_STICKY_CARRY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;

  // Instance with SETTLE_CYCLES = 3
  logic        cmd_valid, cmd_ready, alu_enable, alu_zero, alu_carry;
  logic [15:0] alu_tmp1, alu_tmp2, alu_result, rsp_result;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_carry, rsp_div0;
  logic        sticky_carry, sticky_clr;

  // Instance with SETTLE_CYCLES = 1
  logic        cmd_valid1, cmd_ready1, alu_enable1, alu_zero1, alu_carry1;
  logic [15:0] alu_tmp1_1, alu_tmp2_1, alu_result1, rsp_result1;
  logic [2:0]  alu_op1;
  logic        rsp_valid1, rsp_ready1, rsp_zero1, rsp_carry1, rsp_div01;
  logic        sticky_carry1;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_div0(rsp_div0)
`ifdef ALU_STICKY_CARRY_EN
    , .sticky_carry(sticky_carry), .sticky_clr(sticky_clr)
`endif
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_tmp1(alu_tmp1_1), .alu_tmp2(alu_tmp2_1), .alu_op(alu_op1), .alu_enable(alu_enable1),
    .alu_result(alu_result1), .alu_zero(alu_zero1), .alu_carry(alu_carry1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
    .rsp_zero(rsp_zero1), .rsp_carry(rsp_carry1), .rsp_div0(rsp_div01)
`ifdef ALU_STICKY_CARRY_EN
    , .sticky_carry(sticky_carry1), .sticky_clr(1'b0)
`endif
  );

`ifndef ALU_STICKY_CARRY_EN
  assign sticky_carry  = 1'b0;
  assign sticky_carry1 = 1'b0;
`endif

  // Behavioural Hmmm ALU: returns {carry, zero, result}; carry is signed overflow.
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0]        r;
    logic               c;
    logic signed [31:0] p;
    r = '0;
    c = 1'b0;
    p = '0;
    case (op)
      3'd0: begin r = a + b; c = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; c = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: begin
        p = $signed(a) * $signed(b);
        r = p[15:0];
        c = (p != {{16{p[15]}}, p[15:0]});
      end
      3'd3: if (b != 16'd0) r = 16'($signed(a) / $signed(b));
      3'd4: if (b != 16'd0) r = 16'($signed(a) % $signed(b));
      default: r = '0;
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result}    = alu_f(alu_op, alu_tmp1, alu_tmp2);
  always_comb {alu_carry1, alu_zero1, alu_result1} = alu_f(alu_op1, alu_tmp1_1, alu_tmp2_1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one command to the SETTLE_CYCLES=3 instance; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF;
  endtask

  task automatic wait_rsp(input string tag, input int exp_edges);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_edges));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    rsp_ready = 1'b0; rsp_ready1 = 1'b0; sticky_clr = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_cmd_ready",  32'(cmd_ready), 32'd1);
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_alu_tmp1",   32'(alu_tmp1), 32'd0);
    check("rst_alu_op",     32'(alu_op), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flags",  32'({rsp_zero, rsp_carry, rsp_div0}), 32'd0);
    check("rst_sticky",     32'(sticky_carry), 32'd0);
    check("rst_cmd_ready1", 32'(cmd_ready1), 32'd1);

    // Add on the single-cycle instance: enable for one cycle, response one edge later.
    cmd_op = 3'd0; cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_valid1 = 1'b1; rsp_ready1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    check("add1_enable",    32'(alu_enable1), 32'd1);
    check("add1_busy",      32'({cmd_ready1, rsp_valid1}), 32'd0);
    tick();
    check("add1_enable_off", 32'(alu_enable1), 32'd0);
    check("add1_rsp_valid", 32'(rsp_valid1), 32'd1);
    check("add1_result",    32'(rsp_result1), 32'h0007);
    check("add1_flags",     32'({rsp_zero1, rsp_carry1, rsp_div01}), 32'd0);
    tick();
    check("add1_done",      32'({cmd_ready1, rsp_valid1}), 32'b10);
    rsp_ready1 = 1'b0;

    // Overflow with a 3-cycle settle; operands must not follow the perturbed inputs.
    send(3'd0, 16'h7FFF, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      check("ovf_enable", 32'(alu_enable), 32'd1);
      check("ovf_operands", {alu_tmp1, alu_tmp2}, 32'h7FFF_0001);
      check("ovf_op", 32'(alu_op), 32'd0);
      check("ovf_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("ovf_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ovf_enable_off", 32'(alu_enable), 32'd0);
    check("ovf_result", 32'(rsp_result), 32'h8000);
    check("ovf_flags", 32'({rsp_zero, rsp_carry, rsp_div0}), 32'b010);
    check("ovf_hold_tmp1", 32'(alu_tmp1), 32'h7FFF);
`ifdef ALU_STICKY_CARRY_EN
    check("sticky_set", 32'(sticky_carry), 32'd1);
`endif
    handshake();
    check("ovf_rsp_drop", 32'(rsp_valid), 32'd0);
`ifdef ALU_STICKY_CARRY_EN
    check("sticky_hold", 32'(sticky_carry), 32'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_clr", 32'(sticky_carry), 32'd0);
`endif

    // Zero divisor for div and mod: no ALU issue, immediate fault response.
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 3'd3 : 3'd4, 16'h0010, 16'h0000);
      check("div0_rsp_valid", 32'(rsp_valid), 32'd1);
      check("div0_enable",    32'(alu_enable), 32'd0);
      check("div0_result",    32'(rsp_result), 32'd0);
      check("div0_flags",     32'({rsp_zero, rsp_carry, rsp_div0}), 32'b101);
      handshake();
      check("div0_done",      32'({cmd_ready, rsp_valid}), 32'b10);
    end

    // Backpressure on sub 5-5: response frozen until writeback accepts.
    send(3'd1, 16'd5, 16'd5);
    check("sub_busy", 32'(cmd_ready), 32'd0);
    wait_rsp("sub_latency", 3);
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result",    32'(rsp_result), 32'd0);
      check("bp_flags",     32'({rsp_zero, rsp_carry, rsp_div0}), 32'b100);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    handshake();
    check("bp_release", 32'({cmd_ready, rsp_valid}), 32'b10);

    // Reset while settling drops the command; next multiply completes normally.
    send(3'd0, 16'd1, 16'd1);
    check("rst_mid_enable", 32'(alu_enable), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_state", 32'({cmd_ready, rsp_valid, alu_enable}), 32'b100);
    tick();
    check("rst_mid_quiet", 32'(rsp_valid), 32'd0);
    send(3'd2, 16'hFFFD, 16'h0004);
    wait_rsp("mul_latency", 3);
    check("mul_result", 32'(rsp_result), 32'hFFF4);
    check("mul_flags",  32'({rsp_zero, rsp_carry, rsp_div0}), 32'b000);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
